// File: rtl/data_mem_resp_if.sv
// Request/response bundle between the main decoder (master) and the data-memory responder (slave).
interface data_mem_resp_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [31:0] rdata;
    logic        rvalid;
    logic        wack;
    logic        err;

    modport master (
        output mem_rd, mem_wr, addr, wdata, funct3,
        input  rdata, rvalid, wack, err
    );

    modport slave (
        input  mem_rd, mem_wr, addr, wdata, funct3,
        output rdata, rvalid, wack, err
    );
endinterface

// File: rtl/data_mem_resp.sv
// RV32I data memory: byte/half/word loads and stores, little-endian, one request per cycle,
// single registered response stage carrying load data, store ack or error.
module data_mem_resp #(
    parameter int DEPTH_WORDS = 256
) (
    input logic           clk,
    input logic           rst,
    data_mem_resp_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          req;
    logic          both;
    logic          out_of_range;
    logic          f3_ok;
    logic          misalign;
    logic          bad;
    logic          wr_ok;
    logic          rd_ok;
    logic [3:0]    be;
    logic [31:0]   wd_lanes;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;

    logic [31:0] rdata_q;
    logic        rvalid_q;
    logic        wack_q;
    logic        err_q;

    assign idx          = bus.addr[AW+1:2];
    assign lane         = bus.addr[1:0];
    assign req          = bus.mem_rd | bus.mem_wr;
    assign both         = bus.mem_rd & bus.mem_wr;
    assign out_of_range = |bus.addr[31:AW+2];

    // Stores only know B/H/W; loads add the unsigned byte/half forms.
    always_comb begin
        f3_ok = 1'b0;
        if (bus.mem_wr)
            f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010);
        else
            f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                    (bus.funct3 == 3'b100) || (bus.funct3 == 3'b101);
    end

    assign misalign = ((bus.funct3[1:0] == 2'b01) && lane[0]) ||
                      ((bus.funct3[1:0] == 2'b10) && (lane != 2'b00));

    assign bad   = req & (both | out_of_range | ~f3_ok | misalign);
    assign wr_ok = bus.mem_wr & ~bad;
    assign rd_ok = bus.mem_rd & ~bad;

    // Store data is replicated across lanes so each byte enable picks its own copy.
    always_comb begin
        be       = 4'b0000;
        wd_lanes = bus.wdata;
        case (bus.funct3[1:0])
            2'b00: begin
                be       = 4'b0001 << lane;
                wd_lanes = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{bus.wdata[15:0]}};
            end
            default: begin
                be       = 4'b1111;
                wd_lanes = bus.wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i])
                    mem[idx][8*i +: 8] <= wd_lanes[8*i +: 8];
            end
        end
    end

    assign rd_word = mem[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        case (bus.funct3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // rdata holds across idle and store cycles; an error forces it to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= 32'd0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_ok;
            wack_q   <= wr_ok;
            err_q    <= bad;
            if (bad)
                rdata_q <= 32'd0;
            else if (rd_ok)
                rdata_q <= load_val;
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
    assign bus.wack   = wack_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_data_mem_resp.sv
// Directed plus randomized check of data_mem_resp against a byte-addressed reference model.
module tb_data_mem_resp;
    localparam int D = 256;

    logic clk = 1'b0;
    logic rst = 1'b1;
    data_mem_resp_if bus ();

    data_mem_resp #(.DEPTH_WORDS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mm [4*D];
    logic        exp_v, exp_w, exp_e;
    logic [31:0] exp_d;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_resp(input string tag);
        chk({tag, ".rvalid"}, {31'd0, bus.rvalid}, {31'd0, exp_v});
        chk({tag, ".wack"},   {31'd0, bus.wack},   {31'd0, exp_w});
        chk({tag, ".err"},    {31'd0, bus.err},    {31'd0, exp_e});
        chk({tag, ".rdata"},  bus.rdata,           exp_d);
    endtask

    // Reference behaviour: byte-granular memory, sizes in bytes, explicit extension.
    task automatic model(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [2:0] f3);
        int n;
        bit bad;
        logic [31:0] v;
        n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        bad = (rd && wr) || (longint'(a) >= 4*D) ||
              (wr ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
              ((a % n) != 0);
        exp_v = 1'b0; exp_w = 1'b0; exp_e = 1'b0;
        if (rd || wr) begin
            if (bad) begin
                exp_e = 1'b1;
                exp_d = 32'd0;
            end else if (wr) begin
                for (int k = 0; k < n; k++) mm[int'(a) + k] = wd[8*k +: 8];
                exp_w = 1'b1;
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v = v | (32'(mm[int'(a) + k]) << (8*k));
                if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
                if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
                exp_d = v;
                exp_v = 1'b1;
            end
        end
    endtask

    task automatic req(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3, input string tag);
        bus.mem_rd = rd; bus.mem_wr = wr; bus.addr = a; bus.wdata = wd; bus.funct3 = f3;
        model(rd, wr, a, wd, f3);
        @(posedge clk); #1;
        chk_resp(tag);
    endtask

    task automatic rst_req(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] f3, input string tag);
        rst = 1'b1;
        bus.mem_rd = rd; bus.mem_wr = wr; bus.addr = a; bus.wdata = wd; bus.funct3 = f3;
        exp_v = 1'b0; exp_w = 1'b0; exp_e = 1'b0; exp_d = 32'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_resp(tag);
    endtask

    initial begin
        bus.mem_rd = 1'b0; bus.mem_wr = 1'b0; bus.addr = '0; bus.wdata = '0; bus.funct3 = '0;
        exp_v = 1'b0; exp_w = 1'b0; exp_e = 1'b0; exp_d = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_resp("reset");
        rst = 1'b0;

        // Give every word a known value so later loads are fully predicted.
        for (int w = 0; w < D; w++) req(1'b0, 1'b1, 32'(4*w), $urandom, 3'b010, "preload");

        req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, "sw10");
        req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "lw10");
        chk("lw10_lit", bus.rdata, 32'hDEADBEEF);
        req(1'b0, 1'b0, 32'h0, 32'h0, 3'b000, "idle_hold");

        req(1'b0, 1'b1, 32'h13, 32'h000000A5, 3'b000, "sb13");
        req(1'b1, 1'b0, 32'h13, 32'h0, 3'b000, "lb13");
        chk("lb13_lit", bus.rdata, 32'hFFFFFFA5);
        req(1'b1, 1'b0, 32'h13, 32'h0, 3'b100, "lbu13");
        chk("lbu13_lit", bus.rdata, 32'h000000A5);
        req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "lw10b");
        chk("lw10b_lit", bus.rdata, 32'hA5ADBEEF);

        req(1'b0, 1'b1, 32'h22, 32'h00008001, 3'b001, "sh22");
        req(1'b1, 1'b0, 32'h22, 32'h0, 3'b001, "lh22");
        chk("lh22_lit", bus.rdata, 32'hFFFF8001);
        req(1'b1, 1'b0, 32'h22, 32'h0, 3'b101, "lhu22");
        chk("lhu22_lit", bus.rdata, 32'h00008001);
        req(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, "lw20");
        chk("lw20_hi", {16'd0, bus.rdata[31:16]}, 32'h00008001);

        req(1'b1, 1'b0, 32'h12, 32'h0, 3'b010, "err_lw_mis");
        req(1'b1, 1'b0, 32'h21, 32'h0, 3'b001, "err_lh_mis");
        req(1'b0, 1'b1, 32'(4*D), 32'h12345678, 3'b010, "err_oor");
        req(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, "lw0_after_oor");
        req(1'b1, 1'b1, 32'h20, 32'h55555555, 3'b010, "err_both");
        req(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, "lw20_after_both");
        req(1'b0, 1'b1, 32'h10, 32'h77777777, 3'b100, "err_st_f3");
        req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "lw10_after_f3");
        chk("lw10_after_f3_lit", bus.rdata, 32'hA5ADBEEF);

        for (int i = 0; i < 16; i++) begin
            req(1'b0, 1'b1, 32'h40, 32'h1000 + i, 3'b010, "alt_sw");
            req(1'b1, 1'b0, 32'h40, 32'h0, 3'b010, "alt_lw");
            chk("alt_lit", bus.rdata, 32'h1000 + i);
        end

        req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "pre_rst_lw");
        rst_req(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 3'b010, "rst_mid");
        req(1'b1, 1'b0, 32'h10, 32'h0, 3'b010, "post_rst_lw");
        chk("post_rst_lit", bus.rdata, 32'hA5ADBEEF);

        for (int i = 0; i < 400; i++) begin
            int r;
            bit rd, wr;
            logic [31:0] a;
            logic [2:0] f3;
            r = int'($urandom_range(0, 11));
            rd = (r == 0) || (r >= 2 && r <= 6);
            wr = (r == 0) || (r >= 7);
            a = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4*D - 8, 4*D + 8))
                                             : 32'($urandom_range(0, 4*D - 1));
            f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                              : (wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 2)) | (3'($urandom_range(0, 1)) << 2));
            req(rd, wr, a, $urandom, f3, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the single-cycle RISC-V core: the slave end of the `mem_rd`/`mem_wr` interface driven by the main decoder. It accepts one load or store per cycle with RV32I size and sign semantics (byte/half/word, signed/unsigned loads) in little-endian order. It returns load data, write acknowledges and access errors through a one-cycle registered response stage, and sits between the ALU result/rs2 path and the write-back mux.

## Interface
- `DEPTH_WORDS`, 256: memory depth in 32-bit words; power of two, ≥ 4.
- `clk`  in  1  single clock, all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_rd`  in  1  load request this cycle.
- `mem_wr`  in  1  store request this cycle.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2); the low byte/half is used for SB/SH.
- `funct3`  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `rdata`  out  32  load result, sign/zero-extended; valid when `rvalid`=1.
- `rvalid`  out  1  one-cycle pulse: load completed.
- `wack`  out  1  one-cycle pulse: store committed.
- `err`  out  1  one-cycle pulse: request rejected.

## Operation
- Storage: `DEPTH_WORDS` × 32-bit array with per-byte write enables. Word index is `addr[log2(DEPTH_WORDS)+1:2]` and byte lane is `addr[1:0]`. Contents are not cleared by reset.
- A request is whatever is presented on a rising edge with `rst`=0. There is no backpressure: the block accepts every cycle.
- Error conditions are checked in this order; any one rejects the request, blocks the write, and gives `err`=1, `rdata`=0, `rvalid`=0, `wack`=0 in the response cycle:
  - `mem_rd`=1 and `mem_wr`=1 together;
  - `addr` ≥ 4·`DEPTH_WORDS`;
  - illegal `funct3`: loads accept 000/001/010/100/101; stores accept 000/001/010 only;
  - misalignment: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠00.
- Store: on the accepting edge, write the selected lane(s).
  - SB writes `wdata[7:0]` to lane `addr[1:0]`.
  - SH writes `wdata[15:0]` to lanes `addr[1]`·2 and `addr[1]`·2+1.
  - SW writes all four lanes.
  - Unselected lanes are unchanged. `wack`=1 in the next cycle.
- Load: on the accepting edge, read the word, extract the lane, extend, and register into `rdata`; `rvalid`=1 in the next cycle.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- Idle cycle (`mem_rd`=`mem_wr`=0): all pulses 0 in the next cycle. `rdata` holds its last value.
- Read-after-write: a load accepted the edge after a store to the same word returns the newly written data. A same-edge read and write cannot occur because simultaneous requests are an error.

## Timing
- Response latency: exactly 1 cycle for every request type. Request at edge N gives `rvalid`/`wack`/`err` high for the cycle after edge N, low after edge N+1 unless re-triggered.
- At most one of `rvalid`, `wack`, `err` is high in any cycle.
- Back-to-back requests give back-to-back pulses, e.g. a store at edge N and a load at edge N+1 give `wack` in cycle N+1 and `rvalid` in cycle N+2.
- Reset values: `rdata`=0, `rvalid`=0, `wack`=0, `err`=0.
- Reset mid-operation:
  - A request presented on an edge with `rst`=1 is discarded: no write, no response.
  - A response pending from the previous edge is cleared by that reset edge.
- Memory writes occur only on edges with `rst`=0.

## Test plan
- SW `addr`=0x10, `wdata`=0xDEADBEEF, then LW 0x10 → `wack` in cycle 1; `rvalid` in cycle 2 with `rdata`=0xDEADBEEF.
- SB 0x13 `wdata`=0x000000A5 over that word, then LB 0x13 / LBU 0x13 / LW 0x10 → 0xFFFFFFA5 / 0x000000A5 / 0xA5ADBEEF.
- SH 0x22 `wdata`=0x00008001, then LH 0x22 / LHU 0x22 → 0xFFFF8001 / 0x00008001; LW 0x20 upper half = 0x8001, lower half unchanged.
- Errors, one per cycle, each giving an `err` pulse and no memory change (verified by a subsequent LW):
  - LW 0x12;
  - LH 0x21;
  - SW `addr`=4·`DEPTH_WORDS`;
  - `mem_rd`=`mem_wr`=1;
  - store with `funct3`=100.
- Continuous alternating SW/LW to the same address with incrementing data for 16 cycles → each LW returns the data of the immediately preceding SW; one pulse every cycle.
- Assert `rst` for one edge while a load is pending and an SW is presented → pulses 0 after that edge, `rdata`=0, and a later LW shows the target word unchanged.
